ro_meas_ctrl: RTL and testbench

Measurement sequencer for the on-chip ring-oscillator clock-generator block. It drives the oscillator enable, waits a settle period, and counts oscillator rising edges over a fixed gate window of the system clock. It then reports the count with a one-cycle valid strobe. It sits between the input switches or host logic and the oscillator macro, turning the free-running `clk_G` output into a readable frequency code.

---
 rtl/ro_meas_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ro_meas_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_meas_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ro_meas_ctrl
//  Purpose  : Measurement sequencer for the ring-oscillator clock generator.
//             Enables the oscillator and waits a settle period. It then
//             counts synchronised rising edges of the oscillator output over
//             a fixed window of clk. The result is reported with a one-cycle
//             valid strobe.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//     SETTLE_CYCLES : clk cycles ro_en is high before counting (1..255)
//     GATE_CYCLES   : counting window length in clk cycles (2..65535)
//     CNT_W         : width of the edge counter and of count
//  Ports
//     clk    in   system clock, all state lives here
//     rst_n  in   asynchronous active-low reset
//     start  in   level request, acted on only when idle
//     abort  in   return to idle from any state, highest priority
//     cont   in   continuous mode, sampled in the result cycle
//     ro_clk in   oscillator output, asynchronous to clk
//     ro_en  out  oscillator enable
//     busy   out  high whenever not idle
//     valid  out  one-cycle strobe, count/ovf updated on the same edge
//     count  out  edges counted in the last completed window
//     ovf    out  last window's count saturated
// ============================================================================
module ro_meas_ctrl #(
   parameter int SETTLE_CYCLES = 16,
   parameter int GATE_CYCLES   = 1024,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             cont,
   input  logic             ro_clk,
   output logic             ro_en,
   output logic             busy,
   output logic             valid,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int GATE_W = $clog2(GATE_CYCLES);

   localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [GATE_W-1:0] GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_GATE   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t             state;
   state_t             next_state;
   logic               sync1;
   logic               sync2;
   logic               sync3;
   logic               ro_edge;
   logic [SET_W-1:0]   settle_cnt;
   logic [GATE_W-1:0]  gate_cnt;
   logic [CNT_W-1:0]   edge_cnt;
   logic               edge_ovf;
   logic               load_result;

   // Two synchroniser flops plus one history flop for rising-edge detection.
   // Runs continuously so the pipeline is already primed when GATE starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= ro_clk;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign ro_edge = sync2 & ~sync3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      load_result = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) next_state = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) next_state = S_GATE;
         end
         S_GATE: begin
            if (gate_cnt == GATE_LAST) next_state = S_DONE;
         end
         S_DONE: begin
            load_result = 1'b1;
            next_state  = cont ? S_GATE : S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
      // Abort overrides every transition and suppresses the result load.
      if (abort) begin
         next_state  = S_IDLE;
         load_result = 1'b0;
      end
   end

   // Settle and gate counters restart from zero on every entry into their
   // state, which also covers the DONE -> GATE continuous re-entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
         gate_cnt   <= '0;
      end else begin
         settle_cnt <= (state == S_SETTLE) ? settle_cnt + SET_W'(1) : '0;
         gate_cnt   <= (state == S_GATE)   ? gate_cnt + GATE_W'(1)  : '0;
      end
   end

   // Edges are only accumulated in GATE; any other state clears the counter,
   // so an edge seen in DONE is dropped and each window starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
         edge_ovf <= 1'b0;
      end else if (state != S_GATE) begin
         edge_cnt <= '0;
         edge_ovf <= 1'b0;
      end else if (ro_edge) begin
         if (edge_cnt == CNT_MAX) begin
            edge_ovf <= 1'b1;
         end else begin
            edge_cnt <= edge_cnt + CNT_W'(1);
         end
      end
   end

   // Outputs are registered from next_state so ro_en is glitch-free into the
   // oscillator gate and still clears asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ro_en <= 1'b0;
         busy  <= 1'b0;
         valid <= 1'b0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         ro_en <= (next_state != S_IDLE);
         busy  <= (next_state != S_IDLE);
         valid <= load_result;
         if (load_result) begin
            count <= edge_cnt;
            ovf   <= edge_ovf;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ro_meas_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ro_meas_ctrl
//  Purpose  : Directed self-checking bench for ro_meas_ctrl. Two instances
//             share all inputs: a 16-bit counter instance (a) and a 4-bit
//             counter instance (b) that can saturate. Both use SETTLE=8 and
//             GATE=100.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ro_meas_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        cont = 1'b0;
   logic        ro_clk;
   logic        ro_en_a, busy_a, valid_a, ovf_a;
   logic [15:0] count_a;
   logic        ro_en_b, busy_b, valid_b, ovf_b;
   logic [3:0]  count_b;

   int n_checks = 0;
   int n_fail   = 0;
   int ro_half  = 0;   // oscillator half-period in ns, 0 = held low

   ro_meas_ctrl #(.SETTLE_CYCLES(8), .GATE_CYCLES(100), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
      .ro_clk(ro_clk), .ro_en(ro_en_a), .busy(busy_a), .valid(valid_a),
      .count(count_a), .ovf(ovf_a)
   );

   ro_meas_ctrl #(.SETTLE_CYCLES(8), .GATE_CYCLES(100), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
      .ro_clk(ro_clk), .ro_en(ro_en_b), .busy(busy_b), .valid(valid_b),
      .count(count_b), .ovf(ovf_b)
   );

   always #5 clk = ~clk;

   // Oscillator model, phase-offset from clk (transitions at 3 or 8 mod 10 ns).
   initial begin
      ro_clk = 1'b0;
      #3;
      forever begin
         if (ro_half == 0) begin
            ro_clk = 1'b0;
            #10;
         end else begin
            #(ro_half);
            ro_clk = ~ro_clk;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      while (valid_a !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (ro_en_a !== 1'b0) begin n_fail++; $display("FAIL reset_ro_en got=%b exp=0", ro_en_a); end
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
      n_checks++; if (count_a !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count_a); end
      n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after_release got=%b exp=0", busy_a); end
   endtask

   task automatic test_basic();
      int n;
      ro_half = 50;   // period 10 clk
      repeat (5) tick();
      pulse_start();
      n_checks++; if (ro_en_a !== 1'b1) begin n_fail++; $display("FAIL basic_ro_en_rise got=%b exp=1", ro_en_a); end
      n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got=%b exp=1", busy_a); end
      wait_valid(300, n);
      n_checks++; if (n != 109) begin n_fail++; $display("FAIL basic_latency got=%0d exp=109", n); end
      n_checks++; if (int'(count_a) < 9 || int'(count_a) > 11) begin n_fail++; $display("FAIL basic_count got=%0d exp=10+-1", count_a); end
      n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got=%b exp=0", ovf_a); end
      n_checks++; if (ro_en_a !== 1'b0) begin n_fail++; $display("FAIL basic_ro_en_drop got=%b exp=0", ro_en_a); end
      tick();
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL basic_valid_one_cycle got=%b exp=0", valid_a); end
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall got=%b exp=0", busy_a); end
   endtask

   task automatic test_async_reset();
      pulse_start();
      repeat (50) tick();
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++; if (ro_en_a !== 1'b0) begin n_fail++; $display("FAIL areset_ro_en got=%b exp=0", ro_en_a); end
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL areset_busy got=%b exp=0", busy_a); end
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL areset_valid got=%b exp=0", valid_a); end
      n_checks++; if (count_a !== 16'd0) begin n_fail++; $display("FAIL areset_count got=%0d exp=0", count_a); end
      #2;
      rst_n = 1'b1;
      repeat (3) tick();
      n_checks++; if (busy_a !== 1'b0 || ro_en_a !== 1'b0) begin n_fail++; $display("FAIL areset_stay_idle got=%b%b exp=00", busy_a, ro_en_a); end
   endtask

   task automatic test_overflow();
      int n;
      ro_half = 20;   // period 4 clk -> 25 edges per window
      repeat (5) tick();
      pulse_start();
      wait_valid(300, n);
      n_checks++; if (n != 109) begin n_fail++; $display("FAIL ovf_latency got=%0d exp=109", n); end
      n_checks++; if (count_b !== 4'd15) begin n_fail++; $display("FAIL ovf_count_sat got=%0d exp=15", count_b); end
      n_checks++; if (ovf_b !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", ovf_b); end
      n_checks++; if (int'(count_a) < 24 || int'(count_a) > 26) begin n_fail++; $display("FAIL ovf_wide_count got=%0d exp=25+-1", count_a); end
      n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL ovf_wide_flag got=%b exp=0", ovf_a); end
      tick();
   endtask

   task automatic test_continuous();
      int n;
      int drops;
      int extra;
      ro_half = 50;
      cont = 1'b1;
      repeat (5) tick();
      pulse_start();
      wait_valid(300, n);
      n_checks++; if (n != 109) begin n_fail++; $display("FAIL cont_first_latency got=%0d exp=109", n); end
      drops = 0;
      for (int w = 0; w < 2; w++) begin
         n = 0;
         do begin
            tick();
            n++;
            if (ro_en_a !== 1'b1) drops++;
         end while (valid_a !== 1'b1 && n < 300);
         n_checks++; if (n != 101) begin n_fail++; $display("FAIL cont_period w=%0d got=%0d exp=101", w, n); end
         n_checks++; if (int'(count_a) < 9 || int'(count_a) > 11) begin n_fail++; $display("FAIL cont_count w=%0d got=%0d exp=10+-1", w, count_a); end
      end
      n_checks++; if (drops != 0) begin n_fail++; $display("FAIL cont_ro_en_held got=%0d drops exp=0", drops); end
      cont = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (valid_a !== 1'b1 && n < 300);
      n_checks++; if (n != 101) begin n_fail++; $display("FAIL cont_last_period got=%0d exp=101", n); end
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL cont_end_idle got=%b exp=0", busy_a); end
      extra = 0;
      repeat (150) begin
         tick();
         if (valid_a === 1'b1) extra++;
      end
      n_checks++; if (extra != 0) begin n_fail++; $display("FAIL cont_no_extra_valid got=%0d exp=0", extra); end
   endtask

   task automatic test_back_to_back();
      int n;
      ro_half = 50;
      start = 1'b1;
      tick();
      wait_valid(300, n);
      n_checks++; if (n != 109) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=109", n); end
      n = 0;
      do begin
         tick();
         n++;
      end while (valid_a !== 1'b1 && n < 300);
      n_checks++; if (n != 110) begin n_fail++; $display("FAIL b2b_retrigger_period got=%0d exp=110", n); end
      start = 1'b0;
      tick();
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_stop got=%b exp=0", busy_a); end
   endtask

   task automatic test_zero();
      int n;
      ro_half = 0;
      repeat (10) tick();
      pulse_start();
      wait_valid(300, n);
      n_checks++; if (n != 109) begin n_fail++; $display("FAIL zero_latency got=%0d exp=109", n); end
      n_checks++; if (count_a !== 16'd0) begin n_fail++; $display("FAIL zero_count got=%0d exp=0", count_a); end
      n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL zero_ovf got=%b exp=0", ovf_a); end
      n_checks++; if (count_b !== 4'd0) begin n_fail++; $display("FAIL zero_count_narrow got=%0d exp=0", count_b); end
      tick();
   endtask

   // Runs after the zero-activity window so the held count is known to be 0.
   task automatic test_abort();
      int vseen;
      ro_half = 50;
      repeat (5) tick();
      // abort in GATE, 30 cycles into the window
      pulse_start();
      repeat (38) tick();
      n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL abort_gate_pre_busy got=%b exp=1", busy_a); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++; if (ro_en_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_gate_idle got=%b%b exp=00", ro_en_a, busy_a); end
      vseen = 0;
      repeat (150) begin
         tick();
         if (valid_a === 1'b1) vseen++;
      end
      n_checks++; if (vseen != 0) begin n_fail++; $display("FAIL abort_gate_no_valid got=%0d exp=0", vseen); end
      n_checks++; if (count_a !== 16'd0) begin n_fail++; $display("FAIL abort_gate_count_held got=%0d exp=0", count_a); end
      // abort in SETTLE
      pulse_start();
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++; if (ro_en_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_settle_idle got=%b%b exp=00", ro_en_a, busy_a); end
      repeat (3) tick();
      // abort in DONE
      pulse_start();
      repeat (108) tick();
      n_checks++; if (ro_en_a !== 1'b1) begin n_fail++; $display("FAIL abort_done_pre_ro_en got=%b exp=1", ro_en_a); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL abort_done_valid got=%b exp=0", valid_a); end
      n_checks++; if (ro_en_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_done_idle got=%b%b exp=00", ro_en_a, busy_a); end
      n_checks++; if (count_a !== 16'd0) begin n_fail++; $display("FAIL abort_done_count_held got=%0d exp=0", count_a); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_async_reset();
      test_overflow();
      test_continuous();
      test_back_to_back();
      test_zero();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
